// File: rtl/gf2m_pkg.sv
// gf2m_pkg: shared definitions for the GF(2^m) ALU.
//   GF2M_M / GF2M_POLY / GF2M_D : default field degree, reduction polynomial
//                                 (x^M term implied) and multiplier digit size
//   OP_*                        : operation encodings carried on the op bus
//   gf2m_state_e                : ALU sequencer states
package gf2m_pkg;

  localparam int           GF2M_M    = 163;
  localparam logic [162:0] GF2M_POLY = 163'h0C9;  // x^163 + x^7 + x^6 + x^3 + 1
  localparam int           GF2M_D    = 4;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SQR  = 2'b01;
  localparam logic [1:0] OP_MUL  = 2'b10;
  localparam logic [1:0] OP_SQRN = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADD,
    ST_SQR,
    ST_MUL,
    ST_FIN
  } gf2m_state_e;

endpackage

// File: rtl/gf2m_if.sv
// gf2m_if: request/result bundle between a client and gf2m_alu.
//   start   : operation request (master -> slave)
//   op      : operation select, see OP_* in gf2m_pkg
//   a, b    : operands, M bits
//   sqr_cnt : repeat count for repeated squaring
//   y       : registered result (slave -> master)
//   busy    : operation in progress
//   done    : one-cycle pulse, y valid
interface gf2m_if import gf2m_pkg::*; #(
  parameter int M = GF2M_M
) ();

  logic         start;
  logic [1:0]   op;
  logic [M-1:0] a;
  logic [M-1:0] b;
  logic [7:0]   sqr_cnt;
  logic [M-1:0] y;
  logic         busy;
  logic         done;

  modport master (
    output start, op, a, b, sqr_cnt,
    input  y, busy, done
  );

  modport slave (
    input  start, op, a, b, sqr_cnt,
    output y, busy, done
  );

endinterface

// File: rtl/gf2m_digit_mul.sv
// gf2m_digit_mul: one digit step of an MSB-first digit-serial GF(2^M) multiply.
//   acc      in  M : running product
//   a        in  M : multiplicand
//   digit    in  D : next D bits of the multiplier, MSB first
//   acc_next out M : (acc * x^D + a * digit) mod f, fully reduced
// Purely combinational.
module gf2m_digit_mul import gf2m_pkg::*; #(
  parameter int           M    = GF2M_M,
  parameter int           D    = GF2M_D,
  parameter logic [M-1:0] POLY = M'(GF2M_POLY)
) (
  input  logic [M-1:0] acc,
  input  logic [M-1:0] a,
  input  logic [D-1:0] digit,
  output logic [M-1:0] acc_next
);

  // Horner over the digit bits: multiply by x with immediate reduction,
  // then fold in a when the bit is set, so every partial stays M bits.
  always_comb begin
    acc_next = acc;
    for (int j = D - 1; j >= 0; j--) begin
      acc_next = {acc_next[M-2:0], 1'b0} ^ (acc_next[M-1] ? POLY : '0);
      if (digit[j]) acc_next = acc_next ^ a;
    end
  end

endmodule

// File: rtl/gf2m_alu.sv
// gf2m_alu: GF(2^M) arithmetic unit (add, square, digit-serial multiply,
// repeated square).
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : gf2m_if slave modport (start/op/a/b/sqr_cnt in, y/busy/done out)
// Build option: GF2M_SQR_CHAIN_EN enables op 11 as sqr_cnt repeated squarings;
// without it op 11 is a single squaring and sqr_cnt is ignored.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start, operands latched on start
// ADD     | y = A xor B, one cycle
// SQR     | squaring chain, cnt_q squarings left (1 for plain SQR)
// MUL     | digit-serial multiply, cnt_q digits left, extra cycle at 0
// FIN     | done pulse visible, busy low, start ignored, back to IDLE
module gf2m_alu import gf2m_pkg::*; #(
  parameter int           M    = GF2M_M,
  parameter logic [M-1:0] POLY = M'(GF2M_POLY),
  parameter int           D    = GF2M_D
) (
  input  logic   clk,
  input  logic   rst_n,
  gf2m_if.slave  bus
);

  localparam int N       = (M + D - 1) / D;
  localparam int NW      = N * D;
  localparam int CNT_MAX = (N > 255) ? N : 255;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  gf2m_state_e      state;
  logic [M-1:0]     a_q;
  logic [NW-1:0]    b_q;
  logic [M-1:0]     acc_q;
  logic [M-1:0]     y_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [D-1:0]     digit;
  logic [M-1:0]     mul_next;
  logic [M-1:0]     sqr_next;

  // Spread bits to even positions, then reduce top-down; POLY has degree < M
  // so clearing bit i never sets a bit at or above i.
  function automatic logic [M-1:0] gf_sqr(input logic [M-1:0] v);
    logic [2*M-2:0] t;
    t = '0;
    for (int i = 0; i < M; i++) t[2*i] = v[i];
    for (int i = 2*M - 2; i >= M; i--) begin
      if (t[i]) begin
        t    = t ^ ({{(M-1){1'b0}}, POLY} << (i - M));
        t[i] = 1'b0;
      end
    end
    return t[M-1:0];
  endfunction

  // b_q is zero-padded on the left to N*D bits, so the top digit of a
  // non-multiple width is padded with zeros.
  assign digit    = b_q[NW-1 -: D];
  assign sqr_next = gf_sqr(acc_q);

  gf2m_digit_mul #(.M(M), .D(D), .POLY(POLY)) u_digit_mul (
    .acc      (acc_q),
    .a        (a_q),
    .digit    (digit),
    .acc_next (mul_next)
  );

`ifndef GF2M_SQR_CHAIN_EN
  logic sqr_cnt_unused;
  assign sqr_cnt_unused = ^bus.sqr_cnt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      y_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            a_q    <= bus.a;
            b_q    <= NW'(bus.b);
            busy_q <= 1'b1;
            case (bus.op)
              OP_ADD: begin
                state <= ST_ADD;
                acc_q <= '0;
                cnt_q <= '0;
              end
              OP_MUL: begin
                state <= ST_MUL;
                acc_q <= '0;
                cnt_q <= CNT_W'(N);
              end
              OP_SQRN: begin
                state <= ST_SQR;
                acc_q <= bus.a;
`ifdef GF2M_SQR_CHAIN_EN
                cnt_q <= CNT_W'(bus.sqr_cnt);
`else
                cnt_q <= CNT_W'(1);
`endif
              end
              default: begin
                state <= ST_SQR;
                acc_q <= bus.a;
                cnt_q <= CNT_W'(1);
              end
            endcase
          end
        end

        ST_ADD: begin
          y_q    <= a_q ^ b_q[M-1:0];
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= ST_FIN;
        end

        // cnt_q == 0 only arises from a zero-length chain: result is A itself.
        ST_SQR: begin
          if (cnt_q == '0 || cnt_q == CNT_W'(1)) begin
            y_q    <= (cnt_q == '0) ? acc_q : sqr_next;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= ST_FIN;
          end else begin
            acc_q <= sqr_next;
            cnt_q <= cnt_q - 1'b1;
          end
        end

        // N digit steps, then one cycle to transfer acc_q into y.
        ST_MUL: begin
          if (cnt_q == '0) begin
            y_q    <= acc_q;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= ST_FIN;
          end else begin
            acc_q <= mul_next;
            b_q   <= b_q << D;
            cnt_q <= cnt_q - 1'b1;
          end
        end

        ST_FIN:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.y    = y_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_gf2m_alu.sv
// tb_gf2m_alu: directed and randomized checks of gf2m_alu (M=163, D=4)
// against a schoolbook polynomial-multiply-and-divide model of GF(2^163).
module tb_gf2m_alu;
  import gf2m_pkg::*;

  localparam int M = 163;
  localparam int D = 4;
  localparam logic [M:0] F = {1'b1, 163'h0C9};

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  gf2m_if #(.M(M)) bus ();

  gf2m_alu #(.M(M), .POLY(163'h0C9), .D(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [M-1:0] ref_mul(input logic [M-1:0] x, input logic [M-1:0] z);
    logic [2*M-2:0] p;
    p = '0;
    for (int i = 0; i < M; i++)
      if (z[i]) p = p ^ ({{(M-1){1'b0}}, x} << i);
    for (int k = 2*M - 2; k >= M; k--)
      if (p[k]) p = p ^ ({{(M-2){1'b0}}, F} << (k - M));
    return p[M-1:0];
  endfunction

  function automatic logic [M-1:0] ref_pow2k(input logic [M-1:0] x, input int k);
    logic [M-1:0] r;
    r = x;
    for (int i = 0; i < k; i++) r = ref_mul(r, r);
    return r;
  endfunction

  function automatic logic [M-1:0] rand_elem();
    logic [191:0] t;
    for (int i = 0; i < 6; i++) t[i*32 +: 32] = $urandom;
    return t[M-1:0];
  endfunction

  task automatic check(input string tag, input logic [M-1:0] obs, input logic [M-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_i(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one operation and wait for done; returns at the sample point where
  // done is seen. lat = cycles from the start edge to done, -1 on timeout.
  task automatic run_op(input logic [1:0] op, input logic [M-1:0] a, input logic [M-1:0] b,
                        input logic [7:0] cnt, output logic [M-1:0] y, output int lat,
                        output int busy_cyc);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    bus.sqr_cnt = cnt;
    @(negedge clk);
    bus.start = 1'b0;
    lat = -1;
    busy_cyc = 0;
    y = '0;
    for (int c = 1; c <= 400; c++) begin
      if (bus.busy) busy_cyc++;
      @(negedge clk);
      if (bus.done) begin
        lat = c;
        y = bus.y;
        break;
      end
    end
  endtask

  initial begin
    logic [M-1:0] ra, rb, yo, y2, xa, xb, exp_v;
    int lat, bc, dones;

    bus.start = 1'b0;
    bus.op = OP_ADD;
    bus.a = '0;
    bus.b = '0;
    bus.sqr_cnt = '0;

    // reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_y", bus.y, '0);
    check_i("rst_busy", int'(bus.busy), 0);
    check_i("rst_done", int'(bus.done), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // ADD 5 ^ 3
    run_op(OP_ADD, M'(5), M'(3), 8'd0, yo, lat, bc);
    check("add_y", yo, M'(6));
    check_i("add_lat", lat, 1);
    check_i("add_busy_cycles", bc, 1);
    @(negedge clk);
    check_i("add_done_pulse", int'(bus.done), 0);
    check("add_y_hold", bus.y, M'(6));

    // start during the done cycle is dropped
    run_op(OP_ADD, M'(10), M'(5), 8'd0, yo, lat, bc);
    check("add2_y", yo, M'(15));
    bus.start = 1'b1;
    bus.op = OP_ADD;
    bus.a = M'(1);
    bus.b = M'(2);
    @(negedge clk);
    bus.start = 1'b0;
    check_i("done_start_busy", int'(bus.busy), 0);
    @(negedge clk);
    check_i("done_start_busy2", int'(bus.busy), 0);
    check("done_start_y", bus.y, M'(15));

    // SQR of x^162
    xa = '0;
    xa[162] = 1'b1;
    exp_v = '0;
    exp_v[161] = 1'b1;
    exp_v[12] = 1'b1;
    exp_v[10] = 1'b1;
    exp_v[5] = 1'b1;
    exp_v[1] = 1'b1;
    run_op(OP_SQR, xa, '0, 8'd0, yo, lat, bc);
    check("sqr_y", yo, exp_v);
    check("sqr_model", yo, ref_mul(xa, xa));
    check_i("sqr_lat", lat, 1);

    // MUL x^162 * x
    xb = M'(2);
    run_op(OP_MUL, xa, xb, 8'd0, yo, lat, bc);
    check("mul_y", yo, M'(163'hC9));
    check_i("mul_lat", lat, 42);
    check_i("mul_busy_cycles", bc, 42);

    // op 11
    ra = rand_elem();
`ifdef GF2M_SQR_CHAIN_EN
    run_op(OP_SQRN, ra, '0, 8'd163, yo, lat, bc);
    check("sqrn163_y", yo, ra);
    check_i("sqrn163_lat", lat, 163);
    run_op(OP_SQRN, ra, '0, 8'd0, yo, lat, bc);
    check("sqrn0_y", yo, ra);
    check_i("sqrn0_lat", lat, 1);
    run_op(OP_SQRN, ra, '0, 8'd5, yo, lat, bc);
    check("sqrn5_y", yo, ref_pow2k(ra, 5));
    check_i("sqrn5_lat", lat, 5);
`else
    run_op(OP_SQRN, ra, '0, 8'd9, yo, lat, bc);
    check("sqrn_as_sqr_y", yo, ref_mul(ra, ra));
    check_i("sqrn_as_sqr_lat", lat, 1);
`endif

    // second start held during MUL is ignored
    ra = rand_elem();
    rb = rand_elem();
    exp_v = ref_mul(ra, rb);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = OP_MUL;
    bus.a = ra;
    bus.b = rb;
    @(negedge clk);
    bus.start = 1'b0;
    dones = 0;
    lat = -1;
    yo = '0;
    for (int c = 1; c <= 80; c++) begin
      if (c == 10) begin
        bus.start = 1'b1;
        bus.op = OP_ADD;
        bus.a = rand_elem();
        bus.b = rand_elem();
      end
      if (c == 42) bus.start = 1'b0;
      @(negedge clk);
      if (bus.done) begin
        dones++;
        if (lat < 0) begin
          lat = c;
          yo = bus.y;
        end
      end
    end
    check_i("busy_ign_dones", dones, 1);
    check_i("busy_ign_lat", lat, 42);
    check("busy_ign_y", yo, exp_v);
    check("busy_ign_y_hold", bus.y, exp_v);

    // reset at MUL cycle 20
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = OP_MUL;
    bus.a = rand_elem();
    bus.b = rand_elem();
    @(negedge clk);
    bus.start = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_y", bus.y, '0);
    check_i("midrst_busy", int'(bus.busy), 0);
    check_i("midrst_done", int'(bus.done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (60) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check_i("midrst_no_done", dones, 0);
    check_i("midrst_busy_after", int'(bus.busy), 0);
    run_op(OP_ADD, M'(8'h12), M'(8'h34), 8'd0, yo, lat, bc);
    check("post_rst_add_y", yo, M'(8'h26));
    check_i("post_rst_add_lat", lat, 1);

    // random ADD / SQR
    for (int i = 0; i < 10; i++) begin
      ra = rand_elem();
      rb = rand_elem();
      run_op(OP_ADD, ra, rb, 8'd0, yo, lat, bc);
      check("rnd_add", yo, ra ^ rb);
      run_op(OP_SQR, ra, rb, 8'd0, yo, lat, bc);
      check("rnd_sqr", yo, ref_mul(ra, ra));
    end

    // random MUL against the model, commutativity on a subset
    for (int i = 0; i < 1000; i++) begin
      ra = rand_elem();
      rb = rand_elem();
      run_op(OP_MUL, ra, rb, 8'd0, yo, lat, bc);
      check("rnd_mul", yo, ref_mul(ra, rb));
      if (i % 10 == 0) begin
        run_op(OP_MUL, rb, ra, 8'd0, y2, lat, bc);
        check("rnd_mul_comm", y2, yo);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gf2m_alu.md
GF2M_ALU -- requirements
Module: gf2m_alu

Interface
REQ-001 Parameter M, default 163, SHALL set the field degree and the operand/result width.
REQ-002 Parameter POLY, default 163'h0C9, SHALL hold the reduction polynomial f(x) without the x^M term (default x^163+x^7+x^6+x^3+1).
REQ-003 Parameter D, default 4, SHALL set the multiplier digit size in bits (1 <= D <= M).
REQ-004 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  SHALL be the reset, asynchronous, active-low.
REQ-006 start  in  1  SHALL request an operation; sampled only in IDLE.
REQ-007 op  in  2  SHALL select the operation: 00 ADD, 01 SQR, 10 MUL, 11 SQRN.
REQ-008 a  in  M  SHALL be operand A, sampled with start.
REQ-009 b  in  M  SHALL be operand B, sampled with start.
REQ-010 sqr_cnt  in  8  SHALL give the SQRN repeat count, sampled with start.
REQ-011 y  out  M  SHALL present the registered result.
REQ-012 busy  out  1  SHALL be high while an operation is in progress.
REQ-013 done  out  1  SHALL be a one-cycle pulse marking y valid.

Function
REQ-014 The FSM SHALL have exactly these states: IDLE, ADD, SQR, MUL, FIN.
REQ-015 start in IDLE SHALL latch a, b, op and sqr_cnt, raise busy on the next cycle, and enter the state op selects.
REQ-016 start SHALL be ignored while busy is high, with no effect on latched operands or the result.
REQ-017 ADD SHALL load y = A xor B in one cycle and pulse done one cycle after start.
REQ-018 SQR SHALL load y = A^2 mod f in one cycle and pulse done one cycle after start.
REQ-019 MUL SHALL be MSB-first digit-serial, processing D bits of B per cycle over N = ceil(M/D) cycles, and pulse done N+1 cycles after start.
REQ-020 MUL SHALL zero-pad the top digit of B when M mod D != 0.
REQ-021 FIN SHALL load y, pulse done, clear busy and return to IDLE in the same cycle.
REQ-022 A start arriving in the same cycle as done SHALL be ignored; IDLE is reached only on the following cycle.
REQ-023 y SHALL hold its value between done pulses.
REQ-024 All arithmetic SHALL be in GF(2^m), carry-free, with every result fully reduced to M bits.

Reset
REQ-025 While rst_n is low: y = 0, busy = 0, done = 0, state = IDLE, internal accumulators = 0.
REQ-026 Reset mid-operation SHALL abort the operation with no done pulse.

Configuration
REQ-027 With GF2M_SQR_CHAIN_EN defined, SQRN SHALL square A sqr_cnt times, one squaring per cycle.
REQ-028 SQRN timing with the macro defined: done SHALL pulse max(1, sqr_cnt) cycles after start; sqr_cnt = 0 SHALL return y = A.
REQ-029 With GF2M_SQR_CHAIN_EN undefined, op 11 SHALL behave exactly as SQR and sqr_cnt SHALL be ignored.

Structure
REQ-030 A shared package gf2m_pkg SHALL hold the op encoding constants, the FSM state typedef, and the default M/POLY values.
REQ-031 The digit-step multiply-and-reduce SHALL be a sub-module gf2m_digit_mul (combinational, parameters M, D, POLY).
REQ-032 The squarer SHALL be a combinational function within gf2m_alu.

Verification (M=163, D=4, default POLY)
REQ-033 ADD: a=0x5, b=0x3 -> y=0x6, done one cycle after start, busy high for exactly one cycle.
REQ-034 SQR: a=x^162 -> y = x^161+x^12+x^10+x^5+x; MUL: a=x^162, b=x -> y=0xC9, done 42 cycles after start.
REQ-035 Busy rule: second start asserted during MUL -> ignored, result unchanged, exactly one done pulse.
REQ-036 Reset: rst_n low at MUL cycle 20 -> y=0, busy=0, no done; a fresh ADD then completes normally.
REQ-037 SQRN (macro defined): sqr_cnt=163 -> y=a (Frobenius identity); sqr_cnt=0 -> y=a with done after 1 cycle.
REQ-038 Random: 1000 random (a, b) MUL results -> match a software GF(2^163) model, and MUL(a,b) = MUL(b,a).
